tdc_therm_decoder: RTL and testbench

Downstream consumer of the fine TDC carry-chain sampler. It takes the double-registered thermometer code and removes single-bit bubbles. It detects the first non-zero sample after an idle period and converts it to a binary fine code, then pairs that code with a coarse clock-cycle timestamp. Each hit is presented as one event on a valid/ready stream through a 2-entry output buffer, for the ADC timestamp logic downstream.

---
 rtl/tdc_therm_decoder.sv | 177 +++++++++++++++++
 tb/tb_tdc_therm_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_therm_decoder.sv
// tdc_therm_decoder: turns the double-registered carry-chain thermometer
// code into one timestamped event per hit.
//
// Data path:
//   - stage 1 captures the code together with the coarse count;
//   - stage 2 removes bubbles and registers the popcount and flags;
//   - an arm/hit FSM emits one event per trigger;
//   - events pass through a 2-entry output FIFO.
//
// Optional macro TDC_BUBBLE_FILTER_EN:
//   defined   - 3-input majority bubble filter in stage 2;
//   undefined - stage 2 registers the raw stage-1 code, so latency is unchanged.
//
// FSM states:
//   state     | meaning
//   IDLE_WAIT | waiting for an all-zero sample (trigger released / after reset)
//   ARMED     | zero seen; the next non-zero sample is reported as a hit
module tdc_therm_decoder #(
    parameter  int STAGES   = 64,
    parameter  int COARSE_W = 16,
    localparam int FINE_W   = $clog2(STAGES + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [STAGES-1:0]   therm,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [FINE_W-1:0]   out_fine,
    output logic [COARSE_W-1:0] out_coarse,
    output logic                out_saturated,
    output logic [7:0]          drop_count
);

    typedef enum logic {IDLE_WAIT, ARMED} state_t;

    logic [COARSE_W-1:0] coarse;
    logic [STAGES-1:0]   s1_therm;
    logic [COARSE_W-1:0] s1_coarse;
    logic                s1_valid;
    logic [STAGES-1:0]   filt;
    logic [FINE_W-1:0]   pop_cnt;
    logic                s2_valid;
    logic [FINE_W-1:0]   s2_fine;
    logic [COARSE_W-1:0] s2_coarse;
    logic                s2_ones;
    logic                s2_zero;
    state_t              state, state_next;
    logic                hit;
    logic [FINE_W-1:0]   mem_fine   [2];
    logic [COARSE_W-1:0] mem_coarse [2];
    logic                mem_sat    [2];
    logic                rd_ptr, wr_ptr;
    logic [1:0]          count;
    logic                pop, push_ok, drop;

    // Free-running coarse timestamp, wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) coarse <= '0;
        else       coarse <= coarse + 1'b1;
    end

    // Stage 1: sample the code with the coarse count of the same cycle.
    // The valid bit stops the cleared registers from looking like a zero sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_therm  <= '0;
            s1_coarse <= '0;
            s1_valid  <= 1'b0;
        end else begin
            s1_therm  <= therm;
            s1_coarse <= coarse;
            s1_valid  <= 1'b1;
        end
    end

    // Bubble filter: interior bits take the majority of their neighbourhood.
    always_comb begin
        filt = s1_therm;
`ifdef TDC_BUBBLE_FILTER_EN
        for (int i = 1; i < STAGES - 1; i++) begin
            filt[i] = (s1_therm[i-1] & s1_therm[i]) | (s1_therm[i-1] & s1_therm[i+1]) |
                      (s1_therm[i] & s1_therm[i+1]);
        end
`endif
    end

    // Population count of the filtered code gives the fine code.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            pop_cnt = pop_cnt + FINE_W'(filt[i]);
        end
    end

    // Stage 2: register fine code and the all-ones / all-zero flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_fine   <= '0;
            s2_coarse <= '0;
            s2_ones   <= 1'b0;
            s2_zero   <= 1'b0;
        end else begin
            s2_valid  <= s1_valid;
            s2_fine   <= pop_cnt;
            s2_coarse <= s1_coarse;
            s2_ones   <= &filt;
            s2_zero   <= ~|filt;
        end
    end

    // Arm/hit state register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE_WAIT;
        else       state <= state_next;
    end

    // Arm on a zero sample; report the first non-zero sample once armed.
    always_comb begin
        state_next = state;
        hit        = 1'b0;
        unique case (state)
            IDLE_WAIT: if (s2_valid && s2_zero) state_next = ARMED;
            ARMED: begin
                if (s2_valid && !s2_zero) begin
                    hit        = 1'b1;
                    state_next = IDLE_WAIT;
                end
            end
            default: state_next = IDLE_WAIT;
        endcase
    end

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = hit && ((count != 2'd2) || pop);
    assign drop      = hit && (count == 2'd2) && !pop;

    // Output FIFO storage and pointers; no bypass, so a push shows next cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_fine[i]   <= '0;
                mem_coarse[i] <= '0;
                mem_sat[i]    <= 1'b0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_fine[wr_ptr]   <= s2_fine;
                mem_coarse[wr_ptr] <= s2_coarse;
                mem_sat[wr_ptr]    <= s2_ones;
                wr_ptr             <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Saturating count of events lost to a full FIFO.
    always_ff @(posedge clock) begin
        if (reset)                          drop_count <= 8'd0;
        else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end

    assign out_fine      = mem_fine[rd_ptr];
    assign out_coarse    = mem_coarse[rd_ptr];
    assign out_saturated = mem_sat[rd_ptr];

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Testbench for tdc_therm_decoder: directed scenarios followed by a random
// phase, all checked against a queue-based event model.
module tb_tdc_therm_decoder;
    localparam int STAGES   = 64;
    localparam int COARSE_W = 16;
    localparam int FINE_W   = 7;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [STAGES-1:0]   therm = '0;
    logic                out_ready = 1'b0;
    logic                out_valid;
    logic [FINE_W-1:0]   out_fine;
    logic [COARSE_W-1:0] out_coarse;
    logic                out_saturated;
    logic [7:0]          drop_count;

    tdc_therm_decoder dut (
        .clock(clock), .reset(reset), .therm(therm), .out_ready(out_ready),
        .out_valid(out_valid), .out_fine(out_fine), .out_coarse(out_coarse),
        .out_saturated(out_saturated), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [6:0]  fine;
        logic [15:0] coarse;
        logic        sat;
        logic        zero;
    } samp_t;

    samp_t dl[$];   // samples in flight towards the arm/hit decision
    samp_t q[$];    // expected FIFO contents, head first
    int    mc;      // coarse count during the current cycle
    bit    armed;
    int    mdrop;
    int    checks = 0;
    int    errors = 0;

    function automatic logic [63:0] filter_ref(input logic [63:0] t);
        logic [63:0] f;
        f = t;
`ifdef TDC_BUBBLE_FILTER_EN
        for (int i = 1; i < 63; i++) f[i] = ((int'(t[i-1]) + int'(t[i]) + int'(t[i+1])) >= 2);
`endif
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic compare();
        chk("valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("fine", 64'(out_fine), 64'(q[0].fine));
            chk("coarse", 64'(out_coarse), 64'(q[0].coarse));
            chk("saturated", 64'(out_saturated), 64'(q[0].sat));
        end
        chk("drop_count", 64'(drop_count), 64'(mdrop));
    endtask

    // One clock cycle: drive inputs, advance the model across the edge, check.
    task automatic step(input logic [63:0] t, input bit rdy, input bit rst);
        samp_t       s, e;
        logic [63:0] f;
        therm     = t;
        out_ready = rdy;
        reset     = rst;
        if (rst) begin
            dl.delete();
            q.delete();
            mc    = 0;
            armed = 0;
            mdrop = 0;
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (dl.size() == 2) begin
                e = dl.pop_front();
                if (e.zero) armed = 1;
                else if (armed) begin
                    armed = 0;
                    if (q.size() < 2) q.push_back(e);
                    else if (mdrop < 255) mdrop++;
                end
            end
            f        = filter_ref(t);
            s.fine   = 7'($countones(f));
            s.coarse = 16'(mc);
            s.sat    = (f == '1);
            s.zero   = (f == '0);
            dl.push_back(s);
            mc = (mc + 1) & 16'hFFFF;
        end
        @(posedge clock);
        @(negedge clock);
        compare();
    endtask

    function automatic logic [63:0] therm_code(input int k);
        logic [63:0] one;
        one = 64'd1;
        if (k >= 64) return '1;
        return (one << k) - 64'd1;
    endfunction

    initial begin
        logic [63:0] v;
        int          hit_coarse, k, b;

        // Reset values
        step('0, 1, 1);
        step('0, 1, 1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_fine", 64'(out_fine), 64'd0);
        chk("rst_coarse", 64'(out_coarse), 64'd0);
        chk("rst_sat", 64'(out_saturated), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);

        // Basic hit: 0x1F after two zero samples, visible three cycles later
        step('0, 1, 0);
        step('0, 1, 0);
        hit_coarse = mc;
        step(64'h1F, 1, 0);
        chk("lat_n1", 64'(out_valid), 64'd0);
        step('0, 1, 0);
        chk("lat_n2", 64'(out_valid), 64'd0);
        step('0, 1, 0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_fine", 64'(out_fine), 64'd5);
        chk("t1_sat", 64'(out_saturated), 64'd0);
        chk("t1_coarse", 64'(out_coarse), 64'(hit_coarse));
        step('0, 1, 0);
        step('0, 1, 0);

        // Non-zero straight out of reset is never reported
        step('0, 1, 1);
        for (int i = 0; i < 10; i++) step({$urandom, $urandom} | 64'd1, 1, 0);
        step('0, 1, 0);
        step('0, 1, 0);
        chk("t2_noevt", 64'(out_valid), 64'd0);
        step(64'hFF, 1, 0);
        step('0, 1, 0);
        step('0, 1, 0);
        chk("t2_fine", 64'(out_fine), 64'd8);

        // Bubbles: in 0x2F the lone bit 5 is voted out as well as bit 4 filled in
        step('0, 1, 0);
        step(64'h2F, 1, 0);
        step('0, 1, 0);
        step('0, 1, 0);
        chk("bub2f_fine", 64'(out_fine), 64'd5);
        step(64'h6F, 1, 0);
        step('0, 1, 0);
        step('0, 1, 0);
`ifdef TDC_BUBBLE_FILTER_EN
        chk("bub6f_fine", 64'(out_fine), 64'd7);
`else
        chk("bub6f_fine", 64'(out_fine), 64'd6);
`endif

        // Full-scale hit
        step('1, 1, 0);
        step('0, 1, 0);
        step('0, 1, 0);
        chk("sat_fine", 64'(out_fine), 64'd64);
        chk("sat_flag", 64'(out_saturated), 64'd1);
        step('0, 1, 0);

        // Backpressure: four hits, two held, two dropped, then drain in order
        step(64'h3, 0, 0);
        step('0, 0, 0);
        step(64'hF, 0, 0);
        step('0, 0, 0);
        step(64'hFF, 0, 0);
        step('0, 0, 0);
        step(64'hFFFF, 0, 0);
        step('0, 0, 0);
        step('0, 0, 0);
        chk("bp_drop", 64'(drop_count), 64'd2);
        chk("bp_head", 64'(out_fine), 64'd2);
        step('0, 1, 0);
        chk("bp_second", 64'(out_fine), 64'd4);
        step('0, 1, 0);
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Reset with one entry held and another hit in stage 2
        step(64'h7, 0, 0);
        step('0, 0, 0);
        step('0, 0, 0);
        step(64'hF, 0, 0);
        step('0, 0, 0);
        step('0, 0, 1);
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_drop", 64'(drop_count), 64'd0);
        for (int i = 0; i < 5; i++) step('0, 1, 0);
        chk("mrst_noevt", 64'(out_valid), 64'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(9, 0);
            if (k < 4) v = '0;
            else if (k < 7) begin
                v = therm_code($urandom_range(64, 1));
                if ($urandom_range(2, 0) == 0) begin
                    b = $urandom_range(63, 0);
                    v[b] = ~v[b];
                end
            end else if (k == 7) v = '1;
            else v = {$urandom, $urandom};
            step(v, $urandom_range(3, 0) != 0, $urandom_range(99, 0) == 0);
        end
        for (int i = 0; i < 6; i++) step('0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
